// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for the shared single-port RAM.
// The winning command is registered onto the RAM port; read data is steered back to the requester that issued it.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no owner; round-robin between eligible requesters
// OWN0  | requester 0 holds the lock; only req0 can win
// OWN1  | requester 1 holds the lock; only req1 can win
module ram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   last_q;
    logic   last_d;
    logic   elig0;
    logic   elig1;
    logic   win0;
    logic   win1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // A request still high during its own grant cycle has already been served.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        win0    = 1'b0;
        win1    = 1'b0;
        elig0   = req0 & ~gnt0;
        elig1   = req1 & ~gnt1;

        case (state_q)
            IDLE: begin
                if (elig0 && elig1) begin
                    win0 = last_q;
                    win1 = ~last_q;
                end else begin
                    win0 = elig0;
                    win1 = elig1;
                end
            end
            OWN0:    win0 = elig0;
            OWN1:    win1 = elig1;
            default: state_d = IDLE;
        endcase

        if (win0) begin
            last_d  = 1'b0;
            state_d = lock0 ? OWN0 : IDLE;
        end else if (win1) begin
            last_d  = 1'b1;
            state_d = lock1 ? OWN1 : IDLE;
        end
    end

    // RAM command fields hold their last value when nothing wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            gnt0   <= win0;
            gnt1   <= win1;
            ram_en <= win0 | win1;
            if (win0) begin
                ram_we    <= we0;
                ram_addr  <= addr0;
                ram_wdata <= wdata0;
            end else if (win1) begin
                ram_we    <= we1;
                ram_addr  <= addr1;
                ram_wdata <= wdata1;
            end
        end
    end

    // The RAM answers one cycle after the command, so the grant flags of the
    // command cycle identify who the returning data belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~ram_we;
            rvalid1 <= gnt1 & ~ram_we;
        end
    end

    assign rdata = (rvalid0 | rvalid1) ? ram_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model and a RAM model.
module tb_ram_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req[2];
    logic          we[2];
    logic          lock[2];
    logic [AW-1:0] addr[2];
    logic [DW-1:0] wdata[2];

    logic          gnt0, gnt1, rvalid0, rvalid1, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] rdata, ram_wdata, ram_rdata;
    logic [DW-1:0] ram_mem[16];

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
        .lock0(lock[0]), .lock1(lock[1]), .addr0(addr[0]), .addr1(addr[1]),
        .wdata0(wdata[0]), .wdata1(wdata[1]),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM; contents cleared while reset is held.
    always @(posedge clk) begin
        if (reset) begin
            foreach (ram_mem[k]) ram_mem[k] <= '0;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    int            m_owner;
    int            m_last;
    int            m_rd_who;
    logic [DW-1:0] m_rd_val;
    logic [DW-1:0] m_mem[16];
    bit            e_gnt[2];
    bit            e_rv[2];
    bit            e_en, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rdata;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic gnt_of(input int i);
        return (i == 0) ? gnt0 : gnt1;
    endfunction

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 1;
        m_rd_who = -1;
        m_rd_val = '0;
        foreach (m_mem[k]) m_mem[k] = '0;
        e_gnt = '{0, 0};
        e_rv  = '{0, 0};
        e_en = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_rdata = '0;
    endtask

    // Predicts the outputs seen after the coming rising edge from the current inputs.
    task automatic model_step();
        bit el[2];
        int win;
        if (reset) begin
            model_reset();
            return;
        end
        e_rv[0] = (m_rd_who == 0);
        e_rv[1] = (m_rd_who == 1);
        e_rdata = m_rd_val;
        for (int i = 0; i < 2; i++)
            el[i] = req[i] && !e_gnt[i] && (m_owner < 0 || m_owner == i);
        win = -1;
        if (el[0] && el[1]) win = (m_last == 0) ? 1 : 0;
        else if (el[0])     win = 0;
        else if (el[1])     win = 1;
        e_gnt[0] = (win == 0);
        e_gnt[1] = (win == 1);
        e_en     = (win >= 0);
        m_rd_who = -1;
        if (win >= 0) begin
            e_we    = we[win];
            e_addr  = addr[win];
            e_wdata = wdata[win];
            m_last  = win;
            m_owner = lock[win] ? win : -1;
            if (we[win]) begin
                m_mem[addr[win]] = wdata[win];
            end else begin
                m_rd_who = win;
                m_rd_val = m_mem[addr[win]];
            end
        end
    endtask

    task automatic compare_all();
        check("gnt0",      32'(gnt0),      32'(e_gnt[0]));
        check("gnt1",      32'(gnt1),      32'(e_gnt[1]));
        check("ram_en",    32'(ram_en),    32'(e_en));
        check("ram_we",    32'(ram_we),    32'(e_we));
        check("ram_addr",  32'(ram_addr),  32'(e_addr));
        check("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        check("rvalid0",   32'(rvalid0),   32'(e_rv[0]));
        check("rvalid1",   32'(rvalid1),   32'(e_rv[1]));
        if (e_rv[0] || e_rv[1]) check("rdata", 32'(rdata), 32'(e_rdata));
    endtask

    // Called at a falling edge with inputs set for the next rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    task automatic issue(input int i, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        int k;
        req[i] = 1'b1; we[i] = w; lock[i] = l; addr[i] = a; wdata[i] = d;
        k = 0;
        do begin
            tick();
            k++;
        end while (!gnt_of(i) && k < 12);
        if (!gnt_of(i)) check("issue_timeout", 32'(gnt_of(i)), 32'd1);
        req[i] = 1'b0;
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1; we[i] = 1'b0; lock[i] = 1'b0; wdata[i] = '0;
        end
        addr[0] = 4'd1;
        addr[1] = 4'd2;
        model_reset();

        // Reset with both requesting; outputs stay low throughout.
        @(negedge clk);
        compare_all();
        tick();
        tick();
        reset = 1'b0;

        // Continuous contention straight out of reset: 0,1,0,1,...
        for (int i = 0; i < 8; i++) begin
            tick();
            check("cont_gnt0", 32'(gnt0), 32'(i % 2 == 0));
            check("cont_gnt1", 32'(gnt1), 32'(i % 2 == 1));
        end
        req[0] = 1'b0; req[1] = 1'b0;
        tick();

        // Write then read back by requester 0.
        issue(0, 1'b1, 1'b0, 4'd3, 8'hA5);
        check("wr_we",    32'(ram_we),    32'd1);
        check("wr_wdata", 32'(ram_wdata), 32'hA5);
        issue(0, 1'b0, 1'b0, 4'd3, 8'h00);
        tick();
        check("rd_rvalid0", 32'(rvalid0), 32'd1);
        check("rd_rvalid1", 32'(rvalid1), 32'd0);
        check("rd_rdata",   32'(rdata),   32'hA5);
        tick();

        // Locked read-modify-write by requester 1 while requester 0 waits.
        req[1] = 1'b1; we[1] = 1'b0; lock[1] = 1'b1; addr[1] = 4'd5;
        tick();
        check("lock_gnt1", 32'(gnt1), 32'd1);
        req[1] = 1'b0;
        req[0] = 1'b1; we[0] = 1'b1; lock[0] = 1'b0; addr[0] = 4'd7; wdata[0] = 8'h3C;
        cnt = 0;
        repeat (3) begin
            tick();
            cnt += 32'(gnt0);
        end
        check("lock_hold_gnt0", 32'(cnt), 32'd0);
        req[1] = 1'b1; we[1] = 1'b1; lock[1] = 1'b0; wdata[1] = 8'h5A;
        tick();
        check("unlock_gnt1", 32'(gnt1), 32'd1);
        check("unlock_gnt0", 32'(gnt0), 32'd0);
        req[1] = 1'b0;
        tick();
        check("after_unlock_gnt0", 32'(gnt0), 32'd1);
        req[0] = 1'b0;
        tick();

        // Reset in the cycle after a read grant discards the read.
        issue(1, 1'b0, 1'b0, 4'd5, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("rst_rvalid0", 32'(rvalid0), 32'd0);
        check("rst_rvalid1", 32'(rvalid1), 32'd0);
        @(negedge clk);
        compare_all();
        req[0] = 1'b1; req[1] = 1'b1; we[0] = 1'b0; we[1] = 1'b0;
        lock[0] = 1'b0; lock[1] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("post_rst_gnt0", 32'(gnt0), 32'd1);
        req[0] = 1'b0; req[1] = 1'b0;
        tick();
        tick();

        // Single requester held high: one grant every other cycle.
        req[1] = 1'b1; we[1] = 1'b1; addr[1] = 4'd9; wdata[1] = 8'h77;
        cnt = 0;
        repeat (6) begin
            tick();
            cnt += 32'(gnt1);
        end
        check("single_gnt_count", 32'(cnt), 32'd3);
        req[1] = 1'b0;
        tick();

        // Random traffic with occasional resets.
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req[i] || gnt_of(i)) begin
                    if ($urandom_range(0, 3) != 0) begin
                        req[i]   = 1'b1;
                        we[i]    = 1'($urandom_range(0, 1));
                        lock[i]  = ($urandom_range(0, 3) == 0);
                        addr[i]  = AW'($urandom_range(0, 15));
                        wdata[i] = DW'($urandom);
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
            if ($urandom_range(0, 99) == 0) do_reset(2);
            else tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
